cvita_tlast_check: RTL and testbench

//  Streaming checker/repair stage that sits directly downstream of cvita_insert_tlast, or wherever

---
 rtl/cvita_tlast_check.sv | 186 ++++++++++++++++++
 tb/tb_cvita_tlast_check.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvita_tlast_check.sv
// cvita_tlast_check
// Checks CVITA packet framing against the header length field and re-frames
// the stream so o_tlast lands exactly on beat ceil(len/8). Short packets are
// truncated at the upstream i_tlast, or padded with zero beats up to the
// header length when CVITA_TLAST_CHECK_PAD_EN is defined. Long packets are
// cut at the header length and the excess is drained. Both kinds of framing
// violation raise a one-cycle pulse and bump a saturating counter.

module cvita_tlast_check #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [63:0]      i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [63:0]      o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             err_short,
  output logic             err_long,
  output logic [CNT_W-1:0] short_count,
  output logic [CNT_W-1:0] long_count
);

`ifdef CVITA_TLAST_CHECK_PAD_EN
  typedef enum logic [1:0] {S_HEADER, S_BODY, S_DRAIN, S_PAD} state_t;
`else
  typedef enum logic [1:0] {S_HEADER, S_BODY, S_DRAIN} state_t;
`endif

  state_t           r_state;
  logic [13:0]      r_rem;
  logic             r_errShort;
  logic             r_errLong;
  logic [CNT_W-1:0] r_shortCount;
  logic [CNT_W-1:0] r_longCount;

  logic [15:0]      w_len;
  logic [16:0]      w_lenRound;
  logic [13:0]      w_beats;
  logic             w_hdrSingle;
  logic             w_remLast;
  logic             w_xfer;
`ifdef CVITA_TLAST_CHECK_PAD_EN
  logic             w_padXfer;
`endif

  // The length field is in bytes; a zero length still occupies the header beat.
  assign w_len       = i_tdata[47:32];
  assign w_lenRound  = {1'b0, w_len} + 17'd7;
  assign w_beats     = (w_len == 16'd0) ? 14'd1 : w_lenRound[16:3];
  assign w_hdrSingle = (w_beats == 14'd1);
  assign w_remLast   = (r_rem == 14'd1);
  assign w_xfer      = i_tvalid & i_tready;
`ifdef CVITA_TLAST_CHECK_PAD_EN
  assign w_padXfer   = o_tvalid & o_tready;
`endif

  assign err_short   = r_errShort;
  assign err_long    = r_errLong;
  assign short_count = r_shortCount;
  assign long_count  = r_longCount;

  // Zero-latency datapath steering and regenerated end-of-packet marker.
  always_comb begin
    o_tdata  = i_tdata;
    o_tvalid = i_tvalid;
    i_tready = o_tready;
    o_tlast  = 1'b0;
    case (r_state)
      S_HEADER: begin
`ifdef CVITA_TLAST_CHECK_PAD_EN
        o_tlast = w_hdrSingle;
`else
        o_tlast = w_hdrSingle | i_tlast;
`endif
      end
      S_BODY: begin
`ifdef CVITA_TLAST_CHECK_PAD_EN
        o_tlast = w_remLast;
`else
        o_tlast = w_remLast | i_tlast;
`endif
      end
      S_DRAIN: begin
        o_tvalid = 1'b0;
        i_tready = 1'b1;
      end
`ifdef CVITA_TLAST_CHECK_PAD_EN
      S_PAD: begin
        o_tdata  = 64'h0;
        o_tvalid = 1'b1;
        i_tready = 1'b0;
        o_tlast  = w_remLast;
      end
`endif
      default: begin
        o_tlast = 1'b0;
      end
    endcase
  end

  // Framing state machine, remaining-beat counter, error pulses and counters.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      r_state      <= S_HEADER;
      r_rem        <= 14'd0;
      r_errShort   <= 1'b0;
      r_errLong    <= 1'b0;
      r_shortCount <= '0;
      r_longCount  <= '0;
    end else begin
      r_errShort <= 1'b0;
      r_errLong  <= 1'b0;
      if (r_errShort && (r_shortCount != {CNT_W{1'b1}})) begin
        r_shortCount <= r_shortCount + CNT_W'(1);
      end
      if (r_errLong && (r_longCount != {CNT_W{1'b1}})) begin
        r_longCount <= r_longCount + CNT_W'(1);
      end
      case (r_state)
        S_HEADER: begin
          if (w_xfer) begin
            r_rem <= w_beats - 14'd1;
            if (w_hdrSingle) begin
              if (!i_tlast) begin
                r_errLong <= 1'b1;
                r_state   <= S_DRAIN;
              end
            end else if (i_tlast) begin
              r_errShort <= 1'b1;
`ifdef CVITA_TLAST_CHECK_PAD_EN
              r_state    <= S_PAD;
`endif
            end else begin
              r_state <= S_BODY;
            end
          end
        end
        S_BODY: begin
          if (w_xfer) begin
            r_rem <= r_rem - 14'd1;
            if (w_remLast) begin
              if (i_tlast) begin
                r_state <= S_HEADER;
              end else begin
                r_errLong <= 1'b1;
                r_state   <= S_DRAIN;
              end
            end else if (i_tlast) begin
              r_errShort <= 1'b1;
`ifdef CVITA_TLAST_CHECK_PAD_EN
              r_state    <= S_PAD;
`else
              r_state    <= S_HEADER;
`endif
            end
          end
        end
        S_DRAIN: begin
          if (w_xfer && i_tlast) begin
            r_state <= S_HEADER;
          end
        end
`ifdef CVITA_TLAST_CHECK_PAD_EN
        S_PAD: begin
          if (w_padXfer) begin
            r_rem <= r_rem - 14'd1;
            if (w_remLast) begin
              r_state <= S_HEADER;
            end
          end
        end
`endif
        default: begin
          r_state <= S_HEADER;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cvita_tlast_check.sv
// tb_cvita_tlast_check
// Drives directed and randomized CVITA packets into cvita_tlast_check and
// compares every output beat against a packet-level expectation queue.
// Follows CVITA_TLAST_CHECK_PAD_EN to pick the short-packet behaviour.

module tb_cvita_tlast_check;

`ifdef CVITA_TLAST_CHECK_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic [63:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [63:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic        err_short;
  logic        err_long;
  logic [15:0] short_count;
  logic [15:0] long_count;

  logic        satITready;
  logic [63:0] satOTdata;
  logic        satOTlast;
  logic        satOTvalid;
  logic        satErrShort;
  logic        satErrLong;
  logic [1:0]  satShortCount;
  logic [1:0]  satLongCount;

  beat_t expQ[$];
  beat_t monGot;
  beat_t monExp;
  int    assertCount = 0;
  int    failCount   = 0;
  int    tlastSeen   = 0;
  int    shortPulses = 0;
  int    longPulses  = 0;
  int    expShort    = 0;
  int    expLong     = 0;
  int    tlastBase;
  bit    readyRand   = 1'b0;

  always #5 clk = ~clk;

  cvita_tlast_check #(.CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .err_short(err_short), .err_long(err_long),
    .short_count(short_count), .long_count(long_count)
  );

  cvita_tlast_check #(.CNT_W(2)) dutSat (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(satITready),
    .o_tdata(satOTdata), .o_tlast(satOTlast), .o_tvalid(satOTvalid), .o_tready(o_tready),
    .err_short(satErrShort), .err_long(satErrLong),
    .short_count(satShortCount), .long_count(satLongCount)
  );

  // Scoreboard: every accepted output beat must match the head of the expectation queue.
  always @(negedge clk) begin
    if (reset_n && !clear) begin
      if (o_tvalid && o_tready) begin
        monGot.d = o_tdata;
        monGot.l = o_tlast;
        assertCount++;
        assert (expQ.size() != 0) else begin
          failCount++;
          $error("[TB] FAIL unexpected_beat observed=%h/%0b expected=none", o_tdata, o_tlast);
        end
        if (expQ.size() != 0) begin
          monExp = expQ.pop_front();
          assertCount++;
          assert (monGot === monExp) else begin
            failCount++;
            $error("[TB] FAIL out_beat observed=%h/%0b expected=%h/%0b",
                   monGot.d, monGot.l, monExp.d, monExp.l);
          end
        end
        if (o_tlast) tlastSeen++;
      end
      if (err_short) shortPulses++;
      if (err_long) longPulses++;
      if (err_short || err_long) begin
        assertCount++;
        assert (!(err_short && err_long)) else begin
          failCount++;
          $error("[TB] FAIL err_exclusive observed=both expected=one");
        end
      end
    end
  end

  // Global watchdog so a stuck handshake can never hang the run.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    o_tready = readyRand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic pushExp(input logic [63:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    expQ.push_back(b);
  endtask

  task automatic sendBeat(input logic [63:0] d, input logic l, input bit gaps);
    bit accepted;
    accepted = 1'b0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        i_tvalid = 1'b0;
        tick();
      end
    end
    i_tdata  = d;
    i_tlast  = l;
    i_tvalid = 1'b1;
    for (int c = 0; c < 300 && !accepted; c++) begin
      @(negedge clk);
      accepted = i_tready;
      tick();
    end
    i_tvalid = 1'b0;
    assertCount++;
    assert (accepted) else begin
      failCount++;
      $error("[TB] FAIL beat_accept observed=stalled expected=accepted");
    end
  endtask

  // One packet: header length len, upstream i_tlast on beat n.
  task automatic applyStimulus(input int len, input int n, input bit gaps);
    logic [63:0] d[$];
    logic [63:0] hdr;
    int beats;
    beats = (len == 0) ? 1 : (len + 7) / 8;
    hdr = {$urandom, $urandom};
    hdr[47:32] = len[15:0];
    d.push_back(hdr);
    for (int i = 1; i < n; i++) d.push_back({$urandom, $urandom});
    if (n >= beats) begin
      for (int i = 0; i < beats; i++) pushExp(d[i], i == beats - 1);
      if (n > beats) expLong++;
    end else begin
      expShort++;
      if (PAD) begin
        for (int i = 0; i < n; i++) pushExp(d[i], 1'b0);
        for (int i = n; i < beats; i++) pushExp(64'h0, i == beats - 1);
      end else begin
        for (int i = 0; i < n; i++) pushExp(d[i], i == n - 1);
      end
    end
    for (int i = 0; i < n; i++) sendBeat(d[i], i == n - 1, gaps);
  endtask

  task automatic flush();
    for (int c = 0; c < 1000 && expQ.size() != 0; c++) tick();
    repeat (3) tick();
    checkOutput("queue_drained", expQ.size(), 0);
  endtask

  initial begin
    int len;
    int beats;
    logic [63:0] hdr;
    reset_n  = 1'b0;
    clear    = 1'b0;
    i_tdata  = 64'h0;
    i_tlast  = 1'b0;
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    $display("[TB] reset state");
    checkOutput("rst_short_count", short_count, 0);
    checkOutput("rst_long_count", long_count, 0);
    checkOutput("rst_err_short", err_short, 0);
    checkOutput("rst_err_long", err_long, 0);
    o_tready = 1'b0;
    i_tvalid = 1'b1;
    i_tdata  = 64'h0000_0008_0000_0000;
    @(negedge clk);
    checkOutput("rst_o_tvalid_follows", o_tvalid, 1);
    checkOutput("rst_i_tready_blocked", i_tready, 0);
    i_tvalid = 1'b0;
    tick();

    $display("[TB] good 3-beat packet");
    tlastBase = tlastSeen;
    applyStimulus(24, 3, 1'b0);
    flush();
    checkOutput("t1_tlast_count", tlastSeen - tlastBase, 1);
    checkOutput("t1_short_count", short_count, 0);
    checkOutput("t1_long_count", long_count, 0);

    $display("[TB] single-beat packet then header decode");
    applyStimulus(8, 1, 1'b0);
    applyStimulus(16, 2, 1'b0);
    flush();
    checkOutput("t2_tlast_count", tlastSeen - tlastBase, 3);

    $display("[TB] short packet");
    applyStimulus(32, 2, 1'b0);
    flush();
    checkOutput("t3_short_count", short_count, 1);
    checkOutput("t3_short_pulses", shortPulses, 1);
    checkOutput("t3_long_count", long_count, 0);

    $display("[TB] long packet then good packet");
    applyStimulus(16, 5, 1'b0);
    applyStimulus(8, 1, 1'b0);
    flush();
    checkOutput("t4_long_count", long_count, 1);
    checkOutput("t4_long_pulses", longPulses, 1);
    checkOutput("t4_short_count", short_count, 1);

    $display("[TB] random backpressure, 100 good packets");
    readyRand = 1'b1;
    tlastBase = tlastSeen;
    for (int p = 0; p < 100; p++) begin
      len   = $urandom_range(0, 80);
      beats = (len == 0) ? 1 : (len + 7) / 8;
      applyStimulus(len, beats, 1'b1);
    end
    flush();
    checkOutput("t5_tlast_count", tlastSeen - tlastBase, 100);
    checkOutput("t5_short_count", short_count, 1);
    checkOutput("t5_long_count", long_count, 1);

    $display("[TB] random mixed framing");
    for (int p = 0; p < 40; p++) begin
      len   = $urandom_range(0, 80);
      beats = (len == 0) ? 1 : (len + 7) / 8;
      applyStimulus(len, $urandom_range(1, beats + 2), 1'b1);
    end
    flush();
    checkOutput("t7_short_count", short_count, expShort);
    checkOutput("t7_long_count", long_count, expLong);
    checkOutput("t7_short_pulses", shortPulses, expShort);
    checkOutput("t7_long_pulses", longPulses, expLong);

    $display("[TB] reset mid-body");
    readyRand = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      hdr = {$urandom, $urandom};
      if (i == 0) hdr[47:32] = 16'd40;
      pushExp(hdr, 1'b0);
      sendBeat(hdr, 1'b0, 1'b0);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    expShort = 0;
    expLong  = 0;
    tick();
    checkOutput("t6_short_count_rst", short_count, 0);
    checkOutput("t6_long_count_rst", long_count, 0);
    checkOutput("t6_queue_after_rst", expQ.size(), 0);
    tlastBase = tlastSeen;
    applyStimulus(8, 1, 1'b0);
    flush();
    checkOutput("t6_header_decode_tlast", tlastSeen - tlastBase, 1);
    checkOutput("t6_no_long_after_rst", long_count, 0);
    for (int p = 0; p < 5; p++) applyStimulus(32, 2, 1'b0);
    flush();
    checkOutput("t6_short_count", short_count, 5);
    checkOutput("t6_sat_short_count", satShortCount, 3);

    $display("[TB] clear");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    checkOutput("clr_short_count", short_count, 0);
    checkOutput("clr_sat_short_count", satShortCount, 0);
    applyStimulus(24, 3, 1'b0);
    flush();
    checkOutput("clr_short_after", short_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
